hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller. It generates the `stall` and `flush` inputs that every pipeline register bank (IF/ID, ID/EX, EX/MEM, MEM/WB) consumes. It sits beside the decode/execute boundary and watches three things: ID-stage source registers, the ID/EX outputs (dest, mem_read), and the MEM-stage data-cache handshake. It resolves load-use hazards, branch/jump redirects with multi-cycle fetch refill, and data-memory wait stalls, and flags memory timeouts.

## Interface
- `REG_ID_WIDTH`, 5, register-index width
- `FETCH_LAT`, 2, cycles of stale fetch discarded after a redirect (≥1)
- `MEM_TIMEOUT`, 1024, consecutive memory-wait cycles before `mem_timeout` sets
- `CNT_WIDTH`, 32, performance counter width

- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high; clock `clk`
- `id_rs1`, `id_rs2`  in  REG_ID_WIDTH each  ID-stage source registers
- `id_uses_rs1`, `id_uses_rs2`  in  1 each  ID instruction reads rs1/rs2
- `ex_dest`  in  REG_ID_WIDTH  ID/EX dest_out
- `ex_mem_read`  in  1  ID/EX mem_read (mem_control_out[1])
- `ex_redirect`  in  1  EX resolved taken branch/jump (PC redirect)
- `mem_req_valid`  in  1  MEM stage holds a load/store
- `mem_resp_ready`  in  1  data cache completes the access this cycle
- `pc_stall`, `if_id_stall`, `id_ex_stall`, `ex_mem_stall`  out  1 each  hold the stage
- `if_id_flush`, `id_ex_flush`, `mem_wb_flush`  out  1 each  insert a bubble
- `mem_timeout`  out  1  sticky memory-watchdog error
- `stall_cycles`, `redirect_count`, `load_use_count`  out  CNT_WIDTH each  performance counters

## Operation
- Definitions:
  - `mem_busy` = mem_req_valid & !mem_resp_ready
  - `load_use` = ex_mem_read & ex_dest≠0 & ((id_uses_rs1 & id_rs1==ex_dest) | (id_uses_rs2 & id_rs2==ex_dest))
- FSM states: RUN, REFILL. A down-counter `refill_cnt` has width ⌈log2(FETCH_LAT)⌉+1.
- Priority is evaluated each cycle, with the highest condition winning:
  1. `mem_busy` (any state): pc/if_id/id_ex/ex_mem stall=1 and mem_wb_flush=1. All other flushes are 0. State and refill_cnt are frozen.
  2. `ex_redirect`: if_id_flush=1, id_ex_flush=1, all stalls 0.
     - If FETCH_LAT>1: next state REFILL, refill_cnt←FETCH_LAT-1.
     - Otherwise: stay in RUN.
  3. REFILL (no redirect): if_id_flush=1, nothing else asserted. refill_cnt decrements; on the cycle refill_cnt==1, next state is RUN.
  4. `load_use` in RUN: pc_stall=1, if_id_stall=1, id_ex_flush=1. The load advances to MEM, so the hazard clears the next cycle.
  5. Otherwise all outputs are 0.
- A redirect while in REFILL restarts refill_cnt at FETCH_LAT-1.
- `load_use` is ignored in REFILL, because ID holds a bubble.
- Memory watchdog:
  - `wait_cnt` increments while mem_busy, saturates at MEM_TIMEOUT, and clears to 0 on any cycle mem_busy=0.
  - `mem_timeout` sets when wait_cnt==MEM_TIMEOUT-1 and mem_busy; it stays set until reset.
  - Stalls continue regardless of `mem_timeout`.
- ex_dest==0 never creates a hazard (x0).

## Timing
- All stall/flush outputs are combinational from the current inputs and the registered state. Pipeline registers act on them at the next posedge.
- State, refill_cnt, wait_cnt, mem_timeout and the counters update at posedge clk.
- While reset=1:
  - All stall/flush outputs are forced to 0.
  - Next-cycle state is RUN, refill_cnt=0, wait_cnt=0, mem_timeout=0, counters=0.
- Reset mid-REFILL or mid-wait aborts it immediately.
- Load-use latency: exactly 1 stall cycle per hazard.
- Redirect latency: flush on the redirect cycle, followed by FETCH_LAT-1 IF/ID flush cycles (memory stalls extend this).
- Simultaneous mem_busy and ex_redirect: the stall wins. EX is held, so ex_redirect remains asserted and takes effect on the first cycle with mem_busy=0.

## Configuration
- Macro `HAZARD_PERF_CNT_EN`.
- Defined:
  - `stall_cycles` increments every cycle pc_stall=1.
  - `redirect_count` increments every cycle ex_redirect is acted on (priority 2).
  - `load_use_count` increments every cycle priority 4 fires.
  - Counters wrap at 2^CNT_WIDTH.
- Undefined: the three counter outputs are tied to 0 and no counter flops exist. All other behaviour is identical.

## Test plan
- Load-use: ex_mem_read=1, ex_dest=5, id_rs2=5, id_uses_rs2=1 → one cycle of pc_stall=if_id_stall=id_ex_flush=1; load_use_count=1. The same with ex_dest=0 → no stall.
- Redirect with FETCH_LAT=3: ex_redirect pulse → cycle 0: if_id_flush=id_ex_flush=1; cycles 1–2: if_id_flush only; cycle 3: all 0; redirect_count=1.
- Memory wait: mem_req_valid=1, mem_resp_ready=0 for 4 cycles, then 1 → four cycles of pc/if_id/id_ex/ex_mem stall=1 and mem_wb_flush=1; stall_cycles=4.
- Redirect during memory wait: ex_redirect=1 throughout a 3-cycle mem_busy → no flushes for 3 cycles, then the redirect flush on cycle 4.
- Watchdog with MEM_TIMEOUT=8: 8 consecutive mem_busy cycles → mem_timeout=1 from cycle 8 and stays 1 after mem_resp_ready; clears only on reset.
- Reset asserted in REFILL (refill_cnt=1) → outputs 0 during reset; after release, state RUN with no residual if_id_flush.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, redirect refill and data-memory wait stalls plus a memory watchdog.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int REG_ID_WIDTH = 5,
  parameter int FETCH_LAT    = 2,
  parameter int MEM_TIMEOUT  = 1024,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [REG_ID_WIDTH-1:0] id_rs1,
  input  logic [REG_ID_WIDTH-1:0] id_rs2,
  input  logic                    id_uses_rs1,
  input  logic                    id_uses_rs2,
  input  logic [REG_ID_WIDTH-1:0] ex_dest,
  input  logic                    ex_mem_read,
  input  logic                    ex_redirect,
  input  logic                    mem_req_valid,
  input  logic                    mem_resp_ready,
  output logic                    pc_stall,
  output logic                    if_id_stall,
  output logic                    id_ex_stall,
  output logic                    ex_mem_stall,
  output logic                    if_id_flush,
  output logic                    id_ex_flush,
  output logic                    mem_wb_flush,
  output logic                    mem_timeout,
  output logic [CNT_WIDTH-1:0]    stall_cycles,
  output logic [CNT_WIDTH-1:0]    redirect_count,
  output logic [CNT_WIDTH-1:0]    load_use_count
);

  localparam int RW = $clog2(FETCH_LAT) + 1;
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [RW-1:0] REFILL_INIT = RW'(FETCH_LAT - 1);
  localparam logic [WW-1:0] WAIT_MAX    = WW'(MEM_TIMEOUT);
  localparam logic [WW-1:0] WAIT_LAST   = WW'(MEM_TIMEOUT - 1);

  typedef enum logic {RUN, REFILL} state_t;

  state_t          state;
  logic [RW-1:0]   refill_cnt;
  logic [WW-1:0]   wait_cnt;
  logic            mem_busy;
  logic            load_use;

  assign mem_busy = mem_req_valid & ~mem_resp_ready;
  assign load_use = ex_mem_read && (ex_dest != '0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_dest)) ||
                     (id_uses_rs2 && (id_rs2 == ex_dest)));

  // NOTE: every output gets a default before the priority chain so no latch is inferred.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    if (!reset) begin
      if (mem_busy) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_flush = 1'b1;
      end else if (ex_redirect) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (state == REFILL) begin
        if_id_flush = 1'b1;
      end else if (load_use) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      refill_cnt  <= '0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      // A memory stall freezes the refill sequence; EX still holds any redirect.
      if (!mem_busy) begin
        if (ex_redirect) begin
          if (FETCH_LAT > 1) begin
            state      <= REFILL;
            refill_cnt <= REFILL_INIT;
          end else begin
            state <= RUN;
          end
        end else if (state == REFILL) begin
          if (refill_cnt == RW'(1)) state <= RUN;
          refill_cnt <= refill_cnt - RW'(1);
        end
      end
      if (mem_busy) begin
        if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + WW'(1);
        if (wait_cnt == WAIT_LAST) mem_timeout <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic redirect_fire;
  logic load_use_fire;

  // Only the redirect flushes both IF/ID and ID/EX; only load-use flushes ID/EX alone.
  assign redirect_fire = if_id_flush & id_ex_flush;
  assign load_use_fire = id_ex_flush & ~if_id_flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles   <= '0;
      redirect_count <= '0;
      load_use_count <= '0;
    end else begin
      if (pc_stall)      stall_cycles   <= stall_cycles + CNT_WIDTH'(1);
      if (redirect_fire) redirect_count <= redirect_count + CNT_WIDTH'(1);
      if (load_use_fire) load_use_count <= load_use_count + CNT_WIDTH'(1);
    end
  end
`else
  assign stall_cycles   = '0;
  assign redirect_count = '0;
  assign load_use_count = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then randomized traffic against a cycle-level model.
module tb_hazard_ctrl;
  localparam int RIW = 5;
  localparam int FL  = 3;
  localparam int MT  = 8;
  localparam int CW  = 32;

  logic clk = 1'b0;
  logic reset;
  logic [RIW-1:0] id_rs1, id_rs2, ex_dest;
  logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect;
  logic mem_req_valid, mem_resp_ready;
  logic pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout;
  logic [CW-1:0] stall_cycles, redirect_count, load_use_count;

  hazard_ctrl #(.REG_ID_WIDTH(RIW), .FETCH_LAT(FL), .MEM_TIMEOUT(MT), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_dest(ex_dest), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
    .mem_req_valid(mem_req_valid), .mem_resp_ready(mem_resp_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_mem_stall(ex_mem_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_flush(mem_wb_flush), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .redirect_count(redirect_count), .load_use_count(load_use_count)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  // Reference model: stale-fetch cycles still owed, length of the current memory-wait run.
  int            stale_left = 0;
  int            busy_run   = 0;
  logic          m_timeout  = 1'b0;
  logic [CW-1:0] m_stall    = '0;
  logic [CW-1:0] m_redir    = '0;
  logic [CW-1:0] m_lu       = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Order: pc, if_id, id_ex, ex_mem stalls, then if_id, id_ex, mem_wb flushes.
  function automatic logic [6:0] model_outs();
    logic busy, lu;
    busy = mem_req_valid && !mem_resp_ready;
    lu   = ex_mem_read && (ex_dest != 0) &&
           ((id_uses_rs1 && id_rs1 == ex_dest) || (id_uses_rs2 && id_rs2 == ex_dest));
    if (reset)           return 7'b0000_000;
    if (busy)            return 7'b1111_001;
    if (ex_redirect)     return 7'b0000_110;
    if (stale_left > 0)  return 7'b0000_100;
    if (lu)              return 7'b1100_010;
    return 7'b0000_000;
  endfunction

  task automatic cycle();
    logic [6:0] exp;
    logic busy;
    exp  = model_outs();
    busy = mem_req_valid && !mem_resp_ready;
    #1;
    check("stall_flush", {57'd0, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                          if_id_flush, id_ex_flush, mem_wb_flush}, {57'd0, exp});
    @(posedge clk);
    if (reset) begin
      stale_left = 0; busy_run = 0; m_timeout = 1'b0;
      m_stall = '0; m_redir = '0; m_lu = '0;
    end else begin
      if (busy) begin
        busy_run++;
        if (busy_run >= MT) m_timeout = 1'b1;
      end else begin
        busy_run = 0;
        if (ex_redirect)          stale_left = FL - 1;
        else if (stale_left > 0)  stale_left--;
      end
      if (exp[6])           m_stall++;
      if (exp == 7'b0000_110) m_redir++;
      if (exp == 7'b1100_010) m_lu++;
    end
    #1;
    check("mem_timeout", {63'd0, mem_timeout}, {63'd0, m_timeout});
`ifdef HAZARD_PERF_CNT_EN
    check("stall_cycles",   {32'd0, stall_cycles},   {32'd0, m_stall});
    check("redirect_count", {32'd0, redirect_count}, {32'd0, m_redir});
    check("load_use_count", {32'd0, load_use_count}, {32'd0, m_lu});
`else
    check("stall_cycles",   {32'd0, stall_cycles},   64'd0);
    check("redirect_count", {32'd0, redirect_count}, 64'd0);
    check("load_use_count", {32'd0, load_use_count}, 64'd0);
`endif
  endtask

  task automatic idle();
    reset = 1'b0; id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_dest = '0; ex_mem_read = 1'b0; ex_redirect = 1'b0;
    mem_req_valid = 1'b0; mem_resp_ready = 1'b0;
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) begin idle(); cycle(); end
  endtask

  initial begin
    int busy_left;
    idle();
    reset = 1'b1;
    @(posedge clk); #1;
    cycle(); cycle();
    run_idle(2);

    // Load-use on rs2, then the load moves on.
    ex_mem_read = 1'b1; ex_dest = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    cycle();
    run_idle(1);
    // x0 destination never stalls.
    ex_mem_read = 1'b1; ex_dest = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b1;
    cycle();
    run_idle(1);

    // Redirect pulse: one full flush then FL-1 refill flushes.
    ex_redirect = 1'b1; cycle();
    run_idle(3);

    // Memory wait of four cycles.
    for (int i = 0; i < 4; i++) begin idle(); mem_req_valid = 1'b1; cycle(); end
    idle(); mem_req_valid = 1'b1; mem_resp_ready = 1'b1; cycle();
    run_idle(1);

    // Redirect held through a memory wait takes effect once the wait ends.
    for (int i = 0; i < 3; i++) begin idle(); ex_redirect = 1'b1; mem_req_valid = 1'b1; cycle(); end
    idle(); ex_redirect = 1'b1; cycle();
    run_idle(3);

    // Watchdog trips after MT consecutive wait cycles and stays set.
    for (int i = 0; i < MT + 2; i++) begin idle(); mem_req_valid = 1'b1; cycle(); end
    idle(); mem_req_valid = 1'b1; mem_resp_ready = 1'b1; cycle();
    run_idle(2);

    // Reset in the middle of a refill aborts it and clears the watchdog.
    idle(); ex_redirect = 1'b1; cycle();
    run_idle(1);
    idle(); reset = 1'b1; ex_mem_read = 1'b1; ex_dest = 5'd3; id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
    cycle(); cycle();
    run_idle(2);

    // Randomized traffic with small register indices so hazards are frequent.
    busy_left = 0;
    for (int i = 0; i < 800; i++) begin
      reset          = ($urandom_range(0, 79) == 0);
      id_rs1         = RIW'($urandom_range(0, 3));
      id_rs2         = RIW'($urandom_range(0, 3));
      ex_dest        = RIW'($urandom_range(0, 3));
      id_uses_rs1    = 1'($urandom_range(0, 1));
      id_uses_rs2    = 1'($urandom_range(0, 1));
      ex_mem_read    = 1'($urandom_range(0, 1));
      ex_redirect    = ($urandom_range(0, 7) == 0);
      if (busy_left == 0 && $urandom_range(0, 9) == 0) busy_left = $urandom_range(1, 11);
      if (busy_left > 0) begin
        mem_req_valid = 1'b1; mem_resp_ready = 1'b0; busy_left--;
      end else begin
        mem_req_valid = 1'($urandom_range(0, 1)); mem_resp_ready = 1'b1;
      end
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
